// File: rtl/urng_pair_packer.sv
// Packs pairs of 32-bit Tausworthe words into Box-Muller operands (u0: 48b, u1: 16b)
// and buffers them in a first-word-fall-through FIFO that counts overflow drops.
module urng_pair_packer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              urng_data,
  input  logic                     urng_valid,
  output logic [47:0]              u0,
  output logic [15:0]              u1,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

  typedef enum logic {ST_HI = 1'b0, ST_LO = 1'b1} state_t;

  state_t              state_r;
  logic [31:0]         hold_r;
  logic [63:0]         mem_r [DEPTH];
  logic [AW-1:0]       wr_ptr_r;
  logic [AW-1:0]       rd_ptr_r;
  logic [AW:0]         count_r;
  logic [47:0]         u0_r;
  logic [15:0]         u1_r;
  logic                out_valid_r;
  logic [CNT_W-1:0]    drop_cnt_r;

  logic                push_s;
  logic                pop_s;
  logic                accept_s;
  logic                drop_s;
  logic [63:0]         pair_s;
  logic [AW:0]         remain_s;
  logic [AW:0]         count_next_s;
  logic [AW-1:0]       rd_ptr_next_s;
  logic [63:0]         head_next_s;

  // ln(u0) downstream needs a strictly positive operand.
  function automatic logic [47:0] zero_guard(input logic [47:0] v);
    if (v == 48'h0) begin
      return 48'h000000000001;
    end else begin
      return v;
    end
  endfunction

  // Pair assembly, push/pop arbitration and next head-of-FIFO selection.
  always_comb begin
    push_s        = 1'b0;
    pop_s         = 1'b0;
    accept_s      = 1'b0;
    drop_s        = 1'b0;
    pair_s        = {zero_guard({hold_r, urng_data[31:16]}), urng_data[15:0]};
    remain_s      = count_r;
    count_next_s  = count_r;
    rd_ptr_next_s = rd_ptr_r;
    head_next_s   = {u0_r, u1_r};

    push_s   = urng_valid && (state_r == ST_LO);
    pop_s    = out_valid_r && out_ready;
    accept_s = push_s && ((count_r < FULL_C) || pop_s);
    drop_s   = push_s && !accept_s;

    remain_s     = count_r - {{AW{1'b0}}, pop_s};
    count_next_s = remain_s + {{AW{1'b0}}, accept_s};

    if (pop_s) begin
      rd_ptr_next_s = rd_ptr_r + AW'(1'b1);
    end else begin
      rd_ptr_next_s = rd_ptr_r;
    end

    // With nothing older left, the head is whatever arrives this edge (or idle zero).
    if (remain_s == {(AW+1){1'b0}}) begin
      if (accept_s) begin
        head_next_s = pair_s;
      end else begin
        head_next_s = 64'h0;
      end
    end else if (pop_s) begin
      head_next_s = mem_r[rd_ptr_next_s];
    end else begin
      head_next_s = {u0_r, u1_r};
    end
  end

  // Packer FSM: alternate high/low words on valid cycles only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_HI;
      hold_r  <= 32'h0;
    end else if (urng_valid) begin
      case (state_r)
        ST_HI: begin
          hold_r  <= urng_data;
          state_r <= ST_LO;
        end
        ST_LO: begin
          state_r <= ST_HI;
        end
        default: begin
          state_r <= ST_HI;
        end
      endcase
    end
  end

  // Pair storage; contents need no reset because out_valid gates visibility.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_r[wr_ptr_r] <= pair_s;
    end
  end

  // FIFO pointers, occupancy, registered head and saturating drop counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      count_r     <= {(AW+1){1'b0}};
      u0_r        <= 48'h0;
      u1_r        <= 16'h0;
      out_valid_r <= 1'b0;
      drop_cnt_r  <= {CNT_W{1'b0}};
    end else begin
      if (accept_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      rd_ptr_r     <= rd_ptr_next_s;
      count_r      <= count_next_s;
      {u0_r, u1_r} <= head_next_s;
      out_valid_r  <= (count_next_s != {(AW+1){1'b0}});
      if (drop_s && (drop_cnt_r != {CNT_W{1'b1}})) begin
        drop_cnt_r <= drop_cnt_r + CNT_W'(1'b1);
      end
    end
  end

  assign u0         = u0_r;
  assign u1         = u1_r;
  assign out_valid  = out_valid_r;
  assign fill_level = count_r;
  assign drop_cnt   = drop_cnt_r;

endmodule

// File: doc/urng_pair_packer.md
Name: urng_pair_packer

Overview:
- Downstream consumer of the three-component Tausworthe URNG in the Box-Muller AWGN datapath.
- Packs consecutive 32-bit uniform words into one Box-Muller operand pair:
  - u0, 48 bits, feeds the log/sqrt branch.
  - u1, 16 bits, feeds the sin/cos branch.
- Pairs are held in a small first-word-fall-through (FWFT) FIFO so the free-running URNG is decoupled from the stalling transform pipeline.
- Guards u0 against zero so ln(u0) is always defined.

Parameters:
- DEPTH, 4, number of pair entries in the FIFO; power of two, 2..16.
- CNT_W, 16, width of the saturating dropped-pair counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- urng_data  input  32  uniform word from the URNG.
- urng_valid  input  1  urng_data is valid this cycle; there is no backpressure to the URNG.
- u0  output  48  head-of-FIFO u0 operand.
- u1  output  16  head-of-FIFO u1 operand.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  consumer accepts the head this cycle.
- fill_level  output  $clog2(DEPTH)+1  number of stored pairs.
- drop_cnt  output  CNT_W  number of completed pairs discarded because the FIFO was full; saturates.

Behaviour:
- Reset is synchronous and active-high: reset sampled high at a clock edge clears all state.
  - Packer FSM goes to HI.
  - FIFO is emptied: rd/wr pointers 0, fill_level 0, out_valid 0.
  - u0 = 0, u1 = 0, drop_cnt = 0, hi-word holding register = 0.
  - Reset mid-pair discards the held high word.
- Packer FSM, two states; only cycles with urng_valid=1 advance it:
  - HI: latch urng_data as hold[31:0], go to LO.
  - LO: form the pair from the held word and the current word, then go to HI.
    - u0 = {hold, urng_data[31:16]}.
    - u1 = urng_data[15:0].
    - Assert push for this cycle.
  - urng_valid=0 leaves the state and hold register unchanged.
- Zero guard: if the assembled u0 == 48'h0, store u0 = 48'h000000000001. u1 is stored unchanged. No other values are altered.
- Push rules:
  - A push is accepted if fill_level < DEPTH, or if a pop occurs in the same cycle (full with simultaneous pop).
  - A push that is not accepted discards the pair. drop_cnt increments by 1 and saturates at 2^CNT_W-1.
  - The FSM returns to HI regardless of whether the push was accepted.
- Pop: occurs when out_valid && out_ready. out_ready while empty is ignored.
- FWFT timing:
  - A pair pushed at edge N is visible on u0/u1 with out_valid=1 after edge N (latency one cycle from the second word).
  - Pairs leave in arrival order.
- u0/u1 read 0 whenever out_valid=0. They change only on pop, or on a push into an empty FIFO.
- fill_level updates every edge: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Pointers wrap modulo DEPTH. Full and empty are distinguished by fill_level, not by pointer equality.
- Minimum pair rate is one pair per two valid words. Sustained throughput is 1 pair per 2 cycles when urng_valid=1 continuously.

Test Plan:
- Reset, then words 32'hDEADBEEF and 32'h12345678 on consecutive valid cycles, out_ready=0 -> one cycle after the second word: out_valid=1, u0=48'hDEADBEEF1234, u1=16'h5678, fill_level=1.
- Zero guard: words 32'h00000000 and 32'h0000ABCD -> u0=48'h000000000001, u1=16'hABCD.
- Valid gaps: word A, three idle cycles, word B -> a single pair {A, B[31:16]}/B[15:0]. No pair is pushed while idle.
- Overflow with DEPTH=4, out_ready=0, 12 consecutive valid words (6 pairs) -> fill_level=4, drop_cnt=2, and pairs 1-4 drain in order once out_ready=1.
- Full with simultaneous pop: FIFO full, out_ready=1 held through the cycle a pair completes -> the pair is accepted, drop_cnt unchanged, fill_level stays 4.
- Reset mid-pair: one valid word, then reset, then words 32'h11111111 and 32'h22222222 -> u0=48'h111111112222, u1=16'h2222. The pre-reset word is never used and out_valid=0 until the new pair is pushed.
